// File: rtl/regfile_wb_queue.sv
// Register-file write-port arbiter: ALU writebacks merged with a FIFO of long-latency results.
// Define WBQ_FORWARD_EN to add fwd1/fwd2 data outputs for the youngest queued match.
module regfile_wb_queue #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       alu_we,
  input  logic [4:0]                 alu_wa,
  input  logic [31:0]                alu_wd,
  output logic                       alu_stall,
  input  logic                       llu_valid,
  input  logic [4:0]                 llu_wa,
  input  logic [31:0]                llu_wd,
  output logic                       llu_ready,
  output logic                       we3,
  output logic [4:0]                 wa3,
  output logic [31:0]                wd3,
  input  logic [4:0]                 qa1,
  input  logic [4:0]                 qa2,
  output logic                       pend1,
  output logic                       pend2,
`ifdef WBQ_FORWARD_EN
  output logic [31:0]                fwd1,
  output logic [31:0]                fwd2,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    wa_q [DEPTH];
  logic [31:0]   wd_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we3_q, we3_d;
  logic [4:0]    wa3_q, wa3_d;
  logic [31:0]   wd3_q, wd3_d;
  logic          alu_win, pop, push, alu_hit;
  logic [31:0]   fwd1_c, fwd2_c;
  logic [PW-1:0] idx;

  assign alu_stall = reset_n && (starve_q == SW'(STARVE_MAX)) && (count_q != '0);
  assign llu_ready = reset_n && (count_q < CW'(DEPTH));
  assign alu_win   = !alu_stall && alu_we && (alu_wa != 5'd0);
  assign pop       = reset_n && (count_q != '0) && (alu_stall || !alu_win);
  assign push      = llu_valid && llu_ready && (llu_wa != 5'd0);

  // Walk oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    pend1   = 1'b0;
    pend2   = 1'b0;
    alu_hit = 1'b0;
    fwd1_c  = '0;
    fwd2_c  = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (qa1 != 5'd0 && wa_q[idx] == qa1) begin
          pend1  = 1'b1;
          fwd1_c = wd_q[idx];
        end
        if (qa2 != 5'd0 && wa_q[idx] == qa2) begin
          pend2  = 1'b1;
          fwd2_c = wd_q[idx];
        end
        if (wa_q[idx] == alu_wa) alu_hit = 1'b1;
      end
    end
  end

`ifdef WBQ_FORWARD_EN
  assign fwd1 = fwd1_c;
  assign fwd2 = fwd2_c;
`endif

  always_comb begin
    head_d   = pop  ? head_q + PW'(1) : head_q;
    tail_d   = push ? tail_q + PW'(1) : tail_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (pop) begin
      we3_d = 1'b1;
      wa3_d = wa_q[head_q];
      wd3_d = wd_q[head_q];
    end else if (alu_win) begin
      we3_d = 1'b1;
      wa3_d = alu_wa;
      wd3_d = alu_wd;
    end
    // A nonempty queue that did not pop means the ALU took the slot.
    if (pop || count_q == '0) starve_d = '0;
    else                      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[tail_q] <= llu_wa;
      wd_q[tail_q] <= llu_wd;
    end
  end

  // An ALU write to a still-queued register would be overwritten later by the stale entry.
  always_ff @(posedge clk) begin
    if (reset_n && alu_win) assert (!alu_hit);
  end

  assign we3   = we3_q;
  assign wa3   = wa3_q;
  assign wd3   = wd3_q;
  assign count = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench: directed test-plan cases plus randomized traffic against a queue-based model.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int SMAX  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, alu_we, llu_valid;
  logic [4:0]  alu_wa, llu_wa, qa1, qa2;
  logic [31:0] alu_wd, llu_wd;
  logic        alu_stall, llu_ready, we3, pend1, pend2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [2:0]  count;
`ifdef WBQ_FORWARD_EN
  logic [31:0] fwd1, fwd2;
`endif

  regfile_wb_queue #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_stall(alu_stall),
    .llu_valid(llu_valid), .llu_wa(llu_wa), .llu_wd(llu_wd), .llu_ready(llu_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .qa1(qa1), .qa2(qa2), .pend1(pend1), .pend2(pend2),
`ifdef WBQ_FORWARD_EN
    .fwd1(fwd1), .fwd2(fwd2),
`endif
    .count(count)
  );

  int checks = 0;
  int failures = 0;

  // Model: queued results in order, starvation count, and the registered write port.
  logic [4:0]  m_wa[$];
  logic [31:0] m_wd[$];
  int          m_starve = 0;
  logic        m_we3 = 1'b0;
  logic [4:0]  m_wa3 = '0;
  logic [31:0] m_wd3 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic m_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (m_wa[i]) if (m_wa[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a);
    logic [31:0] r = '0;
    if (a != 5'd0) foreach (m_wa[i]) if (m_wa[i] == a) r = m_wd[i];
    return r;
  endfunction

  task automatic drive(input logic rn, input logic aw, input logic [4:0] awa, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                       input logic [4:0] q1, input logic [4:0] q2);
    reset_n = rn; alu_we = aw; alu_wa = awa; alu_wd = awd;
    llu_valid = lv; llu_wa = lwa; llu_wd = lwd; qa1 = q1; qa2 = q2;
  endtask

  task automatic idle(input logic [4:0] q1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, 5'd0);
  endtask

  // Called at a negedge with inputs applied: compare, advance the model, move to the next negedge.
  task automatic step(input bit cmp);
    bit stall, ready, win, pop, push;
    int n;
    #1;
    n     = m_wa.size();
    stall = reset_n && (m_starve == SMAX) && (n > 0);
    ready = reset_n && (n < DEPTH);
    if (cmp) begin
      chk("count", 32'(count), 32'(n));
      chk("llu_ready", 32'(llu_ready), 32'(ready));
      chk("alu_stall", 32'(alu_stall), 32'(stall));
      chk("we3", 32'(we3), 32'(m_we3));
      chk("wa3", 32'(wa3), 32'(m_wa3));
      chk("wd3", wd3, m_wd3);
      chk("pend1", 32'(pend1), 32'(m_pend(qa1)));
      chk("pend2", 32'(pend2), 32'(m_pend(qa2)));
`ifdef WBQ_FORWARD_EN
      chk("fwd1", fwd1, m_fwd(qa1));
      chk("fwd2", fwd2, m_fwd(qa2));
`endif
    end
    if (!reset_n) begin
      m_wa.delete(); m_wd.delete();
      m_starve = 0; m_we3 = 1'b0; m_wa3 = '0; m_wd3 = '0;
    end else begin
      win  = !stall && alu_we && (alu_wa != 5'd0);
      pop  = (n > 0) && (stall || !win);
      push = llu_valid && ready && (llu_wa != 5'd0);
      if (win) begin
        m_we3 = 1'b1; m_wa3 = alu_wa; m_wd3 = alu_wd;
      end else if (pop) begin
        m_we3 = 1'b1; m_wa3 = m_wa[0]; m_wd3 = m_wd[0];
      end else m_we3 = 1'b0;
      if (pop || n == 0) m_starve = 0;
      else m_starve++;
      if (pop) begin
        void'(m_wa.pop_front()); void'(m_wd.pop_front());
      end
      if (push) begin
        m_wa.push_back(llu_wa); m_wd.push_back(llu_wd);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int pct;
    logic aw, lv;
    logic [4:0] awa, lwa;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    step(0);
    step(1);

    // Reset mid-drain: three queued, one popped, then a one-cycle reset.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'(10 + k), $urandom, 5'd0, 5'd0);
      step(1);
    end
    chk("fill3_count", 32'(count), 32'd3);
    idle(5'd0); step(1);
    chk("drain_wa3", 32'(wa3), 32'd10);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step(1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we3", 32'(we3), 32'd0);
    idle(5'd0); step(1);
    chk("rst_ready", 32'(llu_ready), 32'd1);
    chk("rst_nowrite", 32'(we3), 32'd0);

    // Single ALU write.
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step(1);
    chk("alu_we3", 32'(we3), 32'd1);
    chk("alu_wa3", 32'(wa3), 32'd5);
    chk("alu_wd3", wd3, 32'h1234);
    idle(5'd0); step(1);
    chk("alu_we3_off", 32'(we3), 32'd0);

    // LLU into empty queue, then a handshake to r0.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE, 5'd9, 5'd0); step(1);
    chk("llu_pend", 32'(pend1), 32'd1);
    idle(5'd9); step(1);
    chk("llu_we3", 32'(we3), 32'd1);
    chk("llu_wa3", 32'(wa3), 32'd9);
    chk("llu_wd3", wd3, 32'hCAFE);
    chk("llu_pend_clr", 32'(pend1), 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555, 5'd0, 5'd0); step(1);
    chk("r0_count", 32'(count), 32'd0);
    idle(5'd0); step(1);
    chk("r0_nowrite", 32'(we3), 32'd0);

    // Fill under continuous ALU traffic, then starvation forces one drain.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'(20 + k), $urandom, 5'd21, 5'd23);
      step(1);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(llu_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 5'd1, $urandom, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
      step(1);
    end
    chk("starve_stall", 32'(alu_stall), 32'd1);
    drive(1'b1, 1'b1, 5'd1, 32'hBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step(1);
    chk("starve_wa3", 32'(wa3), 32'd20);
    chk("starve_clr", 32'(alu_stall), 32'd0);
    chk("starve_count", 32'(count), 32'd3);
    repeat (5) begin idle(5'd0); step(1); end

    // Simultaneous enqueue and pop at count=2.
    drive(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0); step(1);
    drive(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0); step(1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0); step(1);
    chk("simul_count", 32'(count), 32'd2);
    chk("order_0", 32'(wa3), 32'd3);
    idle(5'd0); step(1);
    chk("order_1", 32'(wa3), 32'd4);
    idle(5'd0); step(1);
    chk("order_2", 32'(wa3), 32'd6);
    chk("order_2d", wd3, 32'h66);

`ifdef WBQ_FORWARD_EN
    drive(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0); step(1);
    drive(1'b1, 1'b1, 5'd1, $urandom, 1'b1, 5'd7, 32'h22, 5'd7, 5'd0); step(1);
    chk("fwd_pend", 32'(pend1), 32'd1);
    chk("fwd_young", fwd1, 32'h22);
`endif
    repeat (5) begin idle(5'd0); step(1); end

    // Randomized traffic in phases of varying ALU pressure.
    for (int ph = 0; ph < 6; ph++) begin
      pct = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 70 : 95;
      for (int c = 0; c < 500; c++) begin
        aw  = ($urandom_range(99) < pct);
        awa = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
        if (m_pend(awa)) aw = 1'b0;
        lv  = $urandom_range(1);
        lwa = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
        drive(($urandom_range(149) != 0), aw, awa, $urandom, lv, lwa, $urandom,
              5'($urandom_range(15)), 5'($urandom_range(15)));
        step(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
